// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter with bounded bursts in front of the peripheral data port
module dm_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_op,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_op,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    output logic        dm_w,
    output logic        dm_r,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [2:0]  dm_op,
    input  logic [31:0] rdata,
    output logic [1:0]  owner
);
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

    localparam logic [7:0] MB = 8'(MAX_BURST);

    state_t      state_q, state_d;
    logic [7:0]  bcnt_q, bcnt_d, bcnt_inc;
    logic        g0, g1, we_sel;
    logic        dm_w_q, dm_w_d, dm_r_q, dm_r_d;
    logic        m0_gnt_q, m1_gnt_q, m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [2:0]  op_q, op_d;

    assign bcnt_inc = (bcnt_q == 8'hFF) ? 8'hFF : bcnt_q + 8'd1;

    // Pick the winner for this edge: CPU wins ties, owner keeps the port until its burst is spent
    always_comb begin
        state_d = IDLE;
        bcnt_d  = 8'd0;
        g0      = 1'b0;
        g1      = 1'b0;
        case (state_q)
            OWN0: begin
                if (m0_req && (!m1_req || bcnt_q < MB)) begin
                    state_d = OWN0; bcnt_d = bcnt_inc; g0 = 1'b1;
                end else if (m1_req) begin
                    state_d = OWN1; bcnt_d = 8'd1; g1 = 1'b1;
                end
            end
            OWN1: begin
                if (m1_req && (!m0_req || bcnt_q < MB)) begin
                    state_d = OWN1; bcnt_d = bcnt_inc; g1 = 1'b1;
                end else if (m0_req) begin
                    state_d = OWN0; bcnt_d = 8'd1; g0 = 1'b1;
                end
            end
            default: begin
                if (m0_req) begin
                    state_d = OWN0; bcnt_d = 8'd1; g0 = 1'b1;
                end else if (m1_req) begin
                    state_d = OWN1; bcnt_d = 8'd1; g1 = 1'b1;
                end
            end
        endcase
    end

    // Slave-port fields and read return; the capture is steered by the registered grant so a
    // switch at the capture edge cannot hand the data to the new owner
    always_comb begin
        we_sel      = g1 ? m1_we : m0_we;
        dm_w_d      = (g0 | g1) & we_sel;
        dm_r_d      = (g0 | g1) & ~we_sel;
        addr_d      = g0 ? m0_addr  : g1 ? m1_addr  : addr_q;
        wdata_d     = g0 ? m0_wdata : g1 ? m1_wdata : wdata_q;
        op_d        = g0 ? m0_op    : g1 ? m1_op    : op_q;
        m0_rvalid_d = dm_r_q & m0_gnt_q;
        m1_rvalid_d = dm_r_q & m1_gnt_q;
        m0_rdata_d  = m0_rvalid_d ? rdata : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? rdata : m1_rdata_q;
    end

    // State, burst counter and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bcnt_q      <= 8'd0;
            dm_w_q      <= 1'b0;
            dm_r_q      <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            op_q        <= 3'd0;
            m0_rdata_q  <= 32'd0;
            m1_rdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            dm_w_q      <= dm_w_d;
            dm_r_q      <= dm_r_d;
            m0_gnt_q    <= g0;
            m1_gnt_q    <= g1;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign dm_w      = dm_w_q;
    assign dm_r      = dm_r_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign dm_op     = op_q;
    assign owner     = state_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed checks of dm_arbiter with MAX_BURST=4 and MAX_BURST=1 instances
module tb_dm_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0, m1_addr = 32'd0, m1_wdata = 32'd0;
    logic [2:0]  m0_op = 3'd0, m1_op = 3'd0;

    logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_dm_w, a_dm_r;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdata, a_rdata;
    logic [2:0]  a_dm_op;
    logic [1:0]  a_owner;
    logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_dm_w, b_dm_r;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdata, b_rdata;
    logic [2:0]  b_dm_op;
    logic [1:0]  b_owner;

    int n_chk = 0;
    int n_pass = 0;

    // peripheral model: one magic location, otherwise reads return the address itself
    assign a_rdata = (a_addr == 32'h8000_8004) ? 32'hDEAD_BEEF : a_addr;
    assign b_rdata = (b_addr == 32'h8000_8004) ? 32'hDEAD_BEEF : b_addr;

    always #5 clk = ~clk;

    dm_arbiter #(.MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_op(m0_op),
        .m0_gnt(a_m0_gnt), .m0_rdata(a_m0_rdata), .m0_rvalid(a_m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_op(m1_op),
        .m1_gnt(a_m1_gnt), .m1_rdata(a_m1_rdata), .m1_rvalid(a_m1_rvalid),
        .dm_w(a_dm_w), .dm_r(a_dm_r), .addr(a_addr), .wdata(a_wdata), .dm_op(a_dm_op),
        .rdata(a_rdata), .owner(a_owner)
    );

    dm_arbiter #(.MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_op(m0_op),
        .m0_gnt(b_m0_gnt), .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_op(m1_op),
        .m1_gnt(b_m1_gnt), .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid),
        .dm_w(b_dm_w), .dm_r(b_dm_r), .addr(b_addr), .wdata(b_wdata), .dm_op(b_dm_op),
        .rdata(b_rdata), .owner(b_owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_dm_r", 32'(a_dm_r), 0);
        check("rst_dm_w", 32'(a_dm_w), 0);
        check("rst_owner", 32'(a_owner), 0);
        check("rst_addr", a_addr, 0);
        check("rst_m0_rdata", a_m0_rdata, 0);
        check("rst_gnt", {30'd0, a_m0_gnt, a_m1_gnt}, 0);
        rst = 1'b0;
        tick();
        check("idle_owner", 32'(a_owner), 0);

        // single read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8000_8004; m0_op = 3'd2;
        tick();
        check("rd_dm_r", 32'(a_dm_r), 1);
        check("rd_addr", a_addr, 32'h8000_8004);
        check("rd_op", 32'(a_dm_op), 2);
        check("rd_gnt", 32'(a_m0_gnt), 1);
        check("rd_owner", 32'(a_owner), 1);
        m0_req = 1'b0;
        tick();
        check("rd_rvalid", 32'(a_m0_rvalid), 1);
        check("rd_rdata", a_m0_rdata, 32'hDEAD_BEEF);
        check("rd_dm_r_off", 32'(a_dm_r), 0);
        check("rd_owner_idle", 32'(a_owner), 0);
        check("rd_addr_hold", a_addr, 32'h8000_8004);
        tick();
        check("rd_rvalid_off", 32'(a_m0_rvalid), 0);

        // tie from IDLE, then burst fairness with MAX_BURST=4
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("fair_owner%0d", i), 32'(a_owner), ((i / 4) % 2 == 1) ? 2 : 1);
            check($sformatf("fair_gnt%0d", i), {30'd0, a_m1_gnt, a_m0_gnt}, ((i / 4) % 2 == 1) ? 2 : 1);
            check($sformatf("fair_busy%0d", i), 32'(a_dm_r | a_dm_w), 1);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();
        check("fair_idle", 32'(a_owner), 0);

        // m1 write burst, m0 joins during the second write
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hbf80_0000; m1_wdata = 32'd1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("wr_dm_w%0d", i), 32'(a_dm_w), 1);
            check($sformatf("wr_data%0d", i), a_wdata, 32'(i));
            check($sformatf("wr_addr%0d", i), a_addr, 32'hbf80_0000);
            check($sformatf("wr_gnt%0d", i), 32'(a_m1_gnt), 1);
            check($sformatf("wr_rvalid%0d", i), 32'(a_m1_rvalid), 0);
            m1_wdata = 32'(i + 1);
            if (i == 1) begin m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300; end
            if (i == 3) m1_req = 1'b0;
        end
        tick();
        check("wr_sw_gnt", 32'(a_m0_gnt), 1);
        check("wr_sw_dm_r", 32'(a_dm_r), 1);
        check("wr_sw_rvalid", 32'(a_m1_rvalid), 0);
        m0_req = 1'b0;
        tick();
        check("wr_sw_m0_rdata", a_m0_rdata, 32'h300);
        tick();

        // reset while m0 read is on the port
        m0_req = 1'b1; m0_addr = 32'h400;
        tick();
        check("mr_dm_r", 32'(a_dm_r), 1);
        #2 rst = 1'b1;
        #1;
        check("mr_dm_r_async", 32'(a_dm_r), 0);
        check("mr_gnt_async", 32'(a_m0_gnt), 0);
        check("mr_owner_async", 32'(a_owner), 0);
        m0_req = 1'b0;
        tick();
        check("mr_rvalid_rst", 32'(a_m0_rvalid), 0);
        rst = 1'b0;
        tick();
        check("mr_rvalid_post", 32'(a_m0_rvalid), 0);
        check("mr_owner_post", 32'(a_owner), 0);
        tick();
        check("mr_owner_post2", 32'(a_owner), 0);

        // MAX_BURST=1: strict alternation of reads, returns stay with their master
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hA;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hB;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("alt_owner%0d", i), 32'(b_owner), (i % 2 == 0) ? 1 : 2);
            if (i > 0) begin
                check($sformatf("alt_rv%0d", i), {30'd0, b_m1_rvalid, b_m0_rvalid}, ((i - 1) % 2 == 0) ? 1 : 2);
                if ((i - 1) % 2 == 0) check($sformatf("alt_d0_%0d", i), b_m0_rdata, 32'hA);
                else check($sformatf("alt_d1_%0d", i), b_m1_rdata, 32'hB);
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        check("alt_last_rv1", 32'(b_m1_rvalid), 1);
        check("alt_last_d1", b_m1_rdata, 32'hB);
        check("alt_last_d0", b_m0_rdata, 32'hA);
        tick();
        check("alt_idle", 32'(b_owner), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
